// File: rtl/arm7tdmi_pkg.sv
// Shared types and limits for the arm7tdmi memory-side responder.
package arm7tdmi_pkg;

    typedef enum logic [1:0] {
        MR_IDLE,
        MR_WAIT,
        MR_RESPOND
    } mem_resp_state_t;

    localparam int MEM_RESP_MAX_WAIT = 15;

endpackage

// File: rtl/mem_resp_ram.sv
// Word array for the memory responder: per-lane core write, full-word backdoor
// write that wins on collision, and a registered read that sees pre-write data.
module mem_resp_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_be,
    input  logic          bd_we,
    input  logic [AW-1:0] bd_addr,
    input  logic [31:0]   bd_wdata,
    input  logic          rd_en,
    input  logic          rd_clr,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem_r [DEPTH_WORDS];
    logic        bd_hit_s;

    assign bd_hit_s = bd_we && (bd_addr == wr_addr);

    // Array update; a backdoor write to the same word suppresses the core lanes.
    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem_r[bd_addr] <= bd_wdata;
        end
        if (wr_en && !bd_hit_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_r[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read register: holds between completions, cleared on reset or abort.
    always_ff @(posedge clk) begin
        if (!rst_n || rd_clr) begin
            rd_data <= 32'h0000_0000;
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end else begin
            rd_data <= rd_data;
        end
    end

endmodule

// File: rtl/arm7tdmi_mem_responder.sv
// Wait-state memory responder for the arm7tdmi_top memory port.
// Optional feature: define MEM_RESP_ABORT_EN for out-of-range abort completions.
module arm7tdmi_mem_responder
    import arm7tdmi_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_be,
    input  logic          mem_we,
    input  logic          mem_re,
    output logic [31:0]   mem_rdata,
    output logic          mem_ready,
    output logic          mem_abort,
    input  logic          bd_we,
    input  logic [AW-1:0] bd_addr,
    input  logic [31:0]   bd_wdata
);

    localparam int          WAIT_CLAMP = (WAIT_CYCLES > MEM_RESP_MAX_WAIT) ? MEM_RESP_MAX_WAIT : WAIT_CYCLES;
    localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CLAMP);

    mem_resp_state_t state_r, state_n;
    logic [3:0]      wait_cnt_r, wait_cnt_n;
    logic [AW-1:0]   addr_r;
    logic [31:0]     wdata_r;
    logic [3:0]      be_r;
    logic            we_r;
    logic            oob_r;
    logic            ready_r;
    logic            req_s, accept_s, commit_s;
    logic [AW-1:0]   c_addr_s;
    logic [31:0]     c_wdata_s;
    logic [3:0]      c_be_s;
    logic            c_we_s, c_oob_s, in_oob_s;

    assign req_s = mem_re | mem_we;

`ifdef MEM_RESP_ABORT_EN
    logic abort_r;
    logic unused_addr_s;
    assign in_oob_s      = (mem_addr[31:AW+2] != '0);
    assign unused_addr_s = ^mem_addr[1:0];
    assign mem_abort     = abort_r;

    // Abort flag accompanies the completion pulse of an out-of-range access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            abort_r <= 1'b0;
        end else begin
            abort_r <= commit_s & c_oob_s;
        end
    end
`else
    logic unused_addr_s;
    assign in_oob_s      = 1'b0;
    assign unused_addr_s = ^{mem_addr[1:0], mem_addr[31:AW+2]};
    assign mem_abort     = 1'b0;
`endif

    // From MR_IDLE with zero wait states the commit uses the live request.
    assign c_addr_s  = accept_s ? mem_addr[AW+1:2] : addr_r;
    assign c_wdata_s = accept_s ? mem_wdata        : wdata_r;
    assign c_be_s    = accept_s ? mem_be           : be_r;
    assign c_we_s    = accept_s ? mem_we           : we_r;
    assign c_oob_s   = accept_s ? in_oob_s         : oob_r;

    // Next-state, counter and commit decode.
    always_comb begin
        state_n    = state_r;
        wait_cnt_n = wait_cnt_r;
        accept_s   = 1'b0;
        commit_s   = 1'b0;
        if (!rst_n) begin
            state_n    = MR_IDLE;
            wait_cnt_n = 4'd0;
        end else begin
            case (state_r)
                MR_IDLE: begin
                    if (req_s) begin
                        accept_s   = 1'b1;
                        wait_cnt_n = WAIT_LOAD;
                        if (WAIT_LOAD == 4'd0) begin
                            state_n  = MR_RESPOND;
                            commit_s = 1'b1;
                        end else begin
                            state_n = MR_WAIT;
                        end
                    end else begin
                        state_n = MR_IDLE;
                    end
                end
                MR_WAIT: begin
                    if (!req_s) begin
                        state_n    = MR_IDLE;
                        wait_cnt_n = 4'd0;
                    end else begin
                        wait_cnt_n = wait_cnt_r - 4'd1;
                        if (wait_cnt_r == 4'd1) begin
                            state_n  = MR_RESPOND;
                            commit_s = 1'b1;
                        end else begin
                            state_n = MR_WAIT;
                        end
                    end
                end
                MR_RESPOND: begin
                    state_n = MR_IDLE;
                end
                default: begin
                    state_n    = MR_IDLE;
                    wait_cnt_n = 4'd0;
                end
            endcase
        end
    end

    // State, counter, completion pulse and request latches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= MR_IDLE;
            wait_cnt_r <= 4'd0;
            ready_r    <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= 32'h0000_0000;
            be_r       <= 4'b0000;
            we_r       <= 1'b0;
            oob_r      <= 1'b0;
        end else begin
            state_r    <= state_n;
            wait_cnt_r <= wait_cnt_n;
            ready_r    <= commit_s;
            if (accept_s) begin
                addr_r  <= mem_addr[AW+1:2];
                wdata_r <= mem_wdata;
                be_r    <= mem_be;
                we_r    <= mem_we;
                oob_r   <= in_oob_s;
            end else begin
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
                be_r    <= be_r;
                we_r    <= we_r;
                oob_r   <= oob_r;
            end
        end
    end

    assign mem_ready = ready_r;

    mem_resp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (commit_s & c_we_s & ~c_oob_s),
        .wr_addr  (c_addr_s),
        .wr_data  (c_wdata_s),
        .wr_be    (c_be_s),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata),
        .rd_en    (commit_s),
        .rd_clr   (commit_s & c_oob_s),
        .rd_addr  (c_addr_s),
        .rd_data  (mem_rdata)
    );

endmodule
